unpermute_stream: RTL and testbench

//  Inverse of the 16x64-bit word permutation applied to the 1024-bit hash state.

---
 rtl/unpermute_stream.sv | 219 +++++++++++++++++++++
 tb/tb_unpermute_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpermute_stream.sv
// -----------------------------------------------------------------------------
// unpermute_stream
//
// Purpose
//   Undoes the 16 x WORD_W word permutation that was applied to a hash state.
//   It takes one permuted state on the input handshake and streams the
//   recovered state out one word per handshake. Words leave in the order
//   15, 14, ..., 0, and out_last is high with word 0.
//
//   Recovered word j is taken from input word Q[j], where
//     Q[0..15] = 8,3,12,5,10,7,14,1,6,11,2,9,4,13,0,15
//
// Ports
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          in_data holds a permuted state
//   in_ready   out  1          block can accept in_data this cycle
//   in_data    in   16*WORD_W  permuted state; word k = in_data[k*WORD_W +: WORD_W]
//   out_valid  out  1          out_data holds a valid recovered word
//   out_ready  in   1          downstream accepts out_data
//   out_data   out  WORD_W     recovered word, order 15..0
//   out_last   out  1          high with recovered word 0
//   busy       out  1          a block is held or streaming
//
// Handshake
//   Both sides use valid/ready. A transfer happens on a rising clock edge where
//   valid and ready are both high. A source keeps valid and data stable until
//   the transfer. The block keeps out_data and out_last stable while out_valid
//   is high and out_ready is low.
//
// Configuration
//   UNPERMUTE_PREFETCH_EN : adds a second state-wide holding register, so the
//   next block can be taken while the current one streams. Consecutive blocks
//   then leave with no idle cycle between them. When the macro is undefined,
//   a block is accepted only in IDLE, and there is one idle cycle between blocks.
// -----------------------------------------------------------------------------
module unpermute_stream #(
  parameter int WORD_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORD_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int STATE_W = 16 * WORD_W;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              state;
  logic [3:0]          idx;
  logic [STATE_W-1:0]  stream_q;
  logic                out_last_q;
  logic [STATE_W-1:0]  in_mapped;
  logic                take;
  logic                accept;
  logic                hold_full;

  // Source word index for recovered word j.
  function automatic logic [3:0] src_word(input logic [3:0] j);
    logic [3:0] q;
    case (j)
      4'd0:    q = 4'd8;
      4'd1:    q = 4'd3;
      4'd2:    q = 4'd12;
      4'd3:    q = 4'd5;
      4'd4:    q = 4'd10;
      4'd5:    q = 4'd7;
      4'd6:    q = 4'd14;
      4'd7:    q = 4'd1;
      4'd8:    q = 4'd6;
      4'd9:    q = 4'd11;
      4'd10:   q = 4'd2;
      4'd11:   q = 4'd9;
      4'd12:   q = 4'd4;
      4'd13:   q = 4'd13;
      4'd14:   q = 4'd0;
      default: q = 4'd15;
    endcase
    return q;
  endfunction

  // The incoming state is reordered before it is stored. After that, the
  // stream register holds recovered word j in slot j.
  always_comb begin
    in_mapped = '0;
    for (int j = 0; j < 16; j++) begin
      in_mapped[j*WORD_W +: WORD_W] = in_data[int'(src_word(4'(j)))*WORD_W +: WORD_W];
    end
  end

  // The stream register shifts toward its top slot. The top slot is out_data
  // directly, so the output is a pure register with no path from in_data.
  // Zeros shift in, so out_data returns to zero once a block has fully left.
  assign out_data  = stream_q[STATE_W-1 -: WORD_W];
  assign out_last  = out_last_q;
  assign out_valid = (state == S_STREAM);
  assign take      = (state == S_STREAM) && out_ready;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == S_STREAM) || hold_full;

`ifdef UNPERMUTE_PREFETCH_EN
  logic [STATE_W-1:0] hold_q;
  logic               hold_full_q;

  assign hold_full = hold_full_q;
  assign in_ready  = !hold_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 4'd15;
      stream_q    <= '0;
      out_last_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The hold register is always empty here: a full hold is reloaded
          // before the stream could ever return to IDLE.
          if (accept) begin
            stream_q   <= in_mapped;
            idx        <= 4'd15;
            out_last_q <= 1'b0;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (take && idx != 4'd0) begin
            stream_q   <= {stream_q[STATE_W-WORD_W-1:0], {WORD_W{1'b0}}};
            idx        <= idx - 4'd1;
            out_last_q <= (idx == 4'd1);
            if (accept) begin
              hold_q      <= in_mapped;
              hold_full_q <= 1'b1;
            end
          end else if (take) begin
            // The last word is leaving. Start the next block in the same edge
            // when there is one, so out_valid never drops.
            if (hold_full_q) begin
              stream_q    <= hold_q;
              hold_full_q <= 1'b0;
              idx         <= 4'd15;
              out_last_q  <= 1'b0;
            end else if (accept) begin
              stream_q   <= in_mapped;
              idx        <= 4'd15;
              out_last_q <= 1'b0;
            end else begin
              stream_q   <= {stream_q[STATE_W-WORD_W-1:0], {WORD_W{1'b0}}};
              idx        <= 4'd15;
              out_last_q <= 1'b0;
              state      <= S_IDLE;
            end
          end else if (accept) begin
            // Output stalled or not yet taken: park the new block.
            hold_q      <= in_mapped;
            hold_full_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign hold_full = 1'b0;
  assign in_ready  = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 4'd15;
      stream_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            stream_q   <= in_mapped;
            idx        <= 4'd15;
            out_last_q <= 1'b0;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          // in_ready is low here, so a waiting in_valid has no effect.
          if (take) begin
            stream_q <= {stream_q[STATE_W-WORD_W-1:0], {WORD_W{1'b0}}};
            if (idx != 4'd0) begin
              idx        <= idx - 4'd1;
              out_last_q <= (idx == 4'd1);
            end else begin
              idx        <= 4'd15;
              out_last_q <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_unpermute_stream.sv
// -----------------------------------------------------------------------------
// tb_unpermute_stream
//   Self-checking bench for unpermute_stream. Expected words come from the
//   word-mapping rule applied to random states (queue exp_q). Forward-permuted
//   inputs give round-trip checks against the original state.
// -----------------------------------------------------------------------------
module tb_unpermute_stream;

  localparam int W  = 64;
  localparam int DW = 16 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Recovered word j = input word q_map[j].
  int q_map [16] = '{8, 3, 12, 5, 10, 7, 14, 1, 6, 11, 2, 9, 4, 13, 0, 15};
  // Output sequence for input word k = k.
  int known_seq [16] = '{15, 0, 13, 4, 9, 2, 11, 6, 1, 14, 7, 10, 5, 12, 3, 8};

  unpermute_stream #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic logic [DW-1:0] rand_state();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Forward permutation: chosen so that unpermuting gives back s.
  function automatic logic [DW-1:0] forward_perm(input logic [DW-1:0] s);
    logic [DW-1:0] p;
    p = '0;
    for (int j = 0; j < 16; j++) p[q_map[j]*W +: W] = s[j*W +: W];
    return p;
  endfunction

  // Expected output order is original-state word 15 down to word 0.
  task automatic push_state_words(input logic [DW-1:0] s);
    for (int i = 15; i >= 0; i--) exp_q.push_back(s[i*W +: W]);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_block(input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drive_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_known_pattern();
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*W +: W] = W'(k);
    out_ready = 1'b1;
    drive_block(d);
    // One cycle after the accepting edge the first word must be valid.
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL known_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++;
      if (out_data !== W'(known_seq[i])) begin
        errors++; $display("FAIL known_data[%0d]: got %h expected %h", i, out_data, W'(known_seq[i]));
      end
      checks++;
      if (out_last !== (i == 15)) begin errors++; $display("FAIL known_last[%0d]: got %b expected %b", i, out_last, (i == 15)); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL known_end_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL known_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_trip();
    logic [DW-1:0] s;
    logic [W-1:0]  e;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s = rand_state();
      exp_q.delete();
      push_state_words(s);
      drive_block(forward_perm(s));
      for (int i = 0; i < 16; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
          errors++; $display("FAIL round_trip[%0d][%0d]: got v=%b %h expected v=1 %h", b, i, out_valid, out_data, e);
        end
        checks++;
        if (out_last !== (i == 15)) begin errors++; $display("FAIL round_trip_last[%0d][%0d]: got %b", b, i, out_last); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] s;
    logic [W-1:0]  e;
    logic [W-1:0]  held_d;
    logic          held_l;
    logic          stalled;
    logic          rdy;
    int            got;
    int            cyc;
    s = rand_state();
    exp_q.delete();
    push_state_words(s);
    out_ready = 1'b0;
    drive_block(forward_perm(s));
    got = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (got < 16 && cyc < 300) begin
      if (stalled) begin
        checks++;
        if (out_data !== held_d || out_last !== held_l) begin
          errors++; $display("FAIL bp_stable: got %h/%b expected %h/%b", out_data, out_last, held_d, held_l);
        end
      end
      rdy = ((cyc % 3) == 0);
      out_ready = rdy;
      if (out_valid) begin
        if (rdy) begin
          e = exp_q.pop_front();
          checks++;
          if (out_data !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", got, out_data, e); end
          checks++;
          if (out_last !== (got == 15)) begin errors++; $display("FAIL bp_last[%0d]: got %b", got, out_last); end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = out_data;
          held_l  = out_last;
        end
      end else begin
        checks++; errors++;
        $display("FAIL bp_valid_drop: got out_valid 0 expected 1 after %0d words", got);
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL bp_word_count: got %0d expected 16", got); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_word: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_stream();
    logic [DW-1:0] s;
    logic [W-1:0]  e;
    s = rand_state();
    exp_q.delete();
    push_state_words(s);
    out_ready = 1'b1;
    drive_block(forward_perm(s));
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++; $display("FAIL mid_pre[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, e);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid: got %b expected 0", out_valid); end
    s = rand_state();
    push_state_words(s);
    drive_block(forward_perm(s));
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || out_last !== (i == 15)) begin
        errors++; $display("FAIL mid_next[%0d]: got v=%b %h l=%b expected v=1 %h", i, out_valid, out_data, out_last, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] send_s[$];
    logic          hist_v[$];
    logic          hist_r[$];
    logic          hist_b[$];
    logic [W-1:0]  e;
    int            words;
    int            cyc;
    int            acc_n;
    int            acc1_cyc;
    int            acc2_cyc;
    int            first_v;
    int            last_v;
    int            gaps;
    send_s.push_back(rand_state());
    send_s.push_back(rand_state());
    exp_q.delete();
    words = 0; cyc = 0; acc_n = 0; acc1_cyc = 0; acc2_cyc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (words < 32 && cyc < 100) begin
      hist_v.push_back(out_valid);
      hist_r.push_back(in_ready);
      hist_b.push_back(busy);
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", words, out_data, e); end
        checks++;
        if (out_last !== ((words % 16) == 15)) begin errors++; $display("FAIL b2b_last[%0d]: got %b", words, out_last); end
        words++;
      end
      if (send_s.size() > 0) begin
        in_valid = 1'b1;
        in_data  = forward_perm(send_s[0]);
        if (in_ready) begin
          push_state_words(send_s.pop_front());
          if (acc_n == 0) acc1_cyc = cyc; else acc2_cyc = cyc;
          acc_n++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (words != 32) begin errors++; $display("FAIL b2b_word_count: got %0d expected 32", words); end
    first_v = -1; last_v = -1;
    foreach (hist_v[i]) if (hist_v[i]) begin if (first_v < 0) first_v = i; last_v = i; end
    gaps = 0;
    if (first_v >= 0) for (int i = first_v; i <= last_v; i++) if (!hist_v[i]) gaps++;
`ifdef UNPERMUTE_PREFETCH_EN
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 0", gaps); end
    checks++;
    if (acc2_cyc + 1 >= hist_r.size() || hist_r[acc2_cyc+1] !== 1'b0 || hist_b[acc2_cyc+1] !== 1'b1) begin
      errors++; $display("FAIL b2b_hold_full: in_ready/busy after second accept not 0/1 (acc2 cycle %0d)", acc2_cyc);
    end
`else
    checks++; if (gaps != 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 1", gaps); end
    checks++;
    if (acc1_cyc + 1 >= hist_r.size() || hist_r[acc1_cyc+1] !== 1'b0) begin
      errors++; $display("FAIL b2b_in_ready_stream: in_ready not 0 while streaming (acc1 cycle %0d)", acc1_cyc);
    end
`endif
    checks++; if (acc_n != 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_n); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_known_pattern();
    test_round_trip();
    test_backpressure();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
